// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: shared state/lane encodings and default timing
package game_sequencer_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    RUNNING = 4'b0010,
    LOST    = 4'b0100,
    WON     = 4'b1000
  } state_t;
  localparam logic [2:0] LANE_FWD   = 3'b001;
  localparam logic [2:0] LANE_LEFT  = 3'b010;
  localparam logic [2:0] LANE_RIGHT = 3'b100;
  localparam int FWD_FIRST_DEF   = 2;
  localparam int LEFT_FIRST_DEF  = 5;
  localparam int RIGHT_FIRST_DEF = 8;
  localparam int RESPAWN_DEF     = 6;
  localparam int MAX_HEALTH_DEF  = 3;
  localparam int WIN_KILLS_DEF   = 10;
endpackage

// File: rtl/game_sequencer_lane_timer.sv
// game_sequencer_lane_timer: per-lane spawn countdown with pending and occupied flags
module game_sequencer_lane_timer #(
  parameter int FIRST   = 2,
  parameter int RESPAWN = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  input  logic tick,
  input  logic kill,
  input  logic grant,
  output logic pending,
  output logic occupied,
  output logic hit
);
  logic [7:0] count;
  assign hit = run && kill && occupied;
  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      pending  <= 1'b0;
      occupied <= 1'b0;
    end else if (load) begin
      count    <= 8'(FIRST);
      pending  <= 1'b0;
      occupied <= 1'b0;
    end else if (run) begin
      if (hit) begin
        occupied <= 1'b0;
        count    <= 8'(RESPAWN);
      end else if (grant) begin
        occupied <= 1'b1;
        pending  <= 1'b0;
      end else if (tick && !pending && !occupied) begin
        count   <= count == 8'd0 ? count : count - 8'd1;
        pending <= count <= 8'd1;
      end
    end
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game FSM, health/score tracking and round-robin spawn arbiter
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int FWD_FIRST   = FWD_FIRST_DEF,
  parameter int LEFT_FIRST  = LEFT_FIRST_DEF,
  parameter int RIGHT_FIRST = RIGHT_FIRST_DEF,
  parameter int RESPAWN     = RESPAWN_DEF,
  parameter int MAX_HEALTH  = MAX_HEALTH_DEF,
  parameter int WIN_KILLS   = WIN_KILLS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sec_tick,
  input  logic [2:0] kill,
  input  logic       enemy_attack,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [2:0] spawn_lane,
  output logic [2:0] lane_occupied,
  output logic [3:0] game_state,
  output logic [1:0] player_health,
  output logic [7:0] score
);
  state_t state, state_nx;
  logic running, load, accept;
  logic [2:0] pending, hit, grant;
  logic [1:0] ptr, pick, c1, c2, kills, health_nx;
  logic [8:0] sum;
  logic [7:0] score_nx;
  assign running = state == RUNNING;
  assign load = state == IDLE && start;
  assign accept = running && spawn_valid && spawn_ready;
  assign grant = accept ? spawn_lane : 3'b000;
  assign game_state = state;
  for (genvar i = 0; i < 3; i++) begin : g_lane
    game_sequencer_lane_timer #(
      .FIRST(i == 0 ? FWD_FIRST : i == 1 ? LEFT_FIRST : RIGHT_FIRST),
      .RESPAWN(RESPAWN)
    ) u_timer (
      .clk(clk),
      .rst(rst),
      .load(load),
      .run(running),
      .tick(sec_tick),
      .kill(kill[i]),
      .grant(grant[i]),
      .pending(pending[i]),
      .occupied(lane_occupied[i]),
      .hit(hit[i])
    );
  end
  always_comb begin
    c1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    c2 = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    pick = pending[ptr] ? ptr : pending[c1] ? c1 : c2;
    kills = 2'(hit[0]) + 2'(hit[1]) + 2'(hit[2]);
    sum = {1'b0, score} + 9'(kills);
    score_nx = sum[8] ? 8'hff : sum[7:0];
    health_nx = enemy_attack && player_health != 2'd0 ? player_health - 2'd1 : player_health;
    state_nx = state == IDLE ? (start ? RUNNING : IDLE)
             : state == RUNNING ? (health_nx == 2'd0 ? LOST : score_nx >= 8'(WIN_KILLS) ? WON : RUNNING)
             : (start ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      player_health <= '0;
      score         <= '0;
      spawn_valid   <= 1'b0;
      spawn_lane    <= '0;
      ptr           <= '0;
    end else if (load) begin
      player_health <= 2'(MAX_HEALTH);
      score         <= '0;
      spawn_valid   <= 1'b0;
      ptr           <= '0;
    end else if (running) begin
      player_health <= health_nx;
      score         <= score_nx;
      if (accept || state_nx != RUNNING) spawn_valid <= 1'b0;
      else if (!spawn_valid && |pending) begin
        spawn_valid <= 1'b1;
        spawn_lane  <= pick == 2'd0 ? LANE_FWD : pick == 2'd1 ? LANE_LEFT : LANE_RIGHT;
        ptr         <= pick == 2'd2 ? 2'd0 : pick + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of spawn timing, arbitration, scoring and game outcome
module tb_game_sequencer;
  logic clk = 1'b0;
  logic rst, start, sec_tick, enemy_attack, spawn_ready;
  logic [2:0] kill;
  logic spawn_valid, w_valid;
  logic [2:0] spawn_lane, lane_occupied, w_lane, w_occ;
  logic [3:0] game_state, w_state;
  logic [1:0] player_health, w_health;
  logic [7:0] score, w_score;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  game_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick), .kill(kill),
    .enemy_attack(enemy_attack), .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .lane_occupied(lane_occupied), .game_state(game_state),
    .player_health(player_health), .score(score)
  );
  game_sequencer #(.WIN_KILLS(1)) u_win (
    .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick), .kill(kill),
    .enemy_attack(enemy_attack), .spawn_ready(spawn_ready), .spawn_valid(w_valid),
    .spawn_lane(w_lane), .lane_occupied(w_occ), .game_state(w_state),
    .player_health(w_health), .score(w_score)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
  endtask
  task automatic accept_one();
    spawn_ready = 1'b1;
    cyc();
    spawn_ready = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(game_state), 32'h1);
    chk({tag, "_valid"}, 32'(spawn_valid), 32'h0);
    chk({tag, "_lane"}, 32'(spawn_lane), 32'h0);
    chk({tag, "_occ"}, 32'(lane_occupied), 32'h0);
    chk({tag, "_health"}, 32'(player_health), 32'h0);
    chk({tag, "_score"}, 32'(score), 32'h0);
  endtask
  initial begin
    rst = 1'b0; start = 1'b0; sec_tick = 1'b0; kill = 3'b000;
    enemy_attack = 1'b0; spawn_ready = 1'b0;
    cyc(); cyc();
    chk_reset("rst");
    rst = 1'b1;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("run_state", 32'(game_state), 32'h2);
    chk("run_health", 32'(player_health), 32'h3);
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_in_run", 32'(game_state), 32'h2);
    tick();
    chk("t1_valid", 32'(spawn_valid), 32'h0);
    tick();
    chk("t2_valid_late", 32'(spawn_valid), 32'h0);
    cyc();
    chk("fwd_valid", 32'(spawn_valid), 32'h1);
    chk("fwd_lane", 32'(spawn_lane), 32'h1);
    accept_one();
    chk("fwd_occ", 32'(lane_occupied), 32'h1);
    chk("fwd_drop", 32'(spawn_valid), 32'h0);
    kill = 3'b001; cyc(); kill = 3'b000;
    chk("kill_score", 32'(score), 32'h1);
    chk("kill_occ", 32'(lane_occupied), 32'h0);
    kill = 3'b010; cyc(); kill = 3'b000;
    chk("empty_kill", 32'(score), 32'h1);
    tick(); tick(); tick();
    cyc();
    chk("left_valid", 32'(spawn_valid), 32'h1);
    chk("left_lane", 32'(spawn_lane), 32'h2);
    accept_one();
    chk("left_occ", 32'(lane_occupied), 32'h2);
    tick(); tick();
    cyc();
    chk("no_early_respawn", 32'(spawn_valid), 32'h0);
    tick();
    cyc();
    chk("rr_right_lane", 32'(spawn_lane), 32'h4);
    chk("rr_right_valid", 32'(spawn_valid), 32'h1);
    accept_one();
    chk("idle_gap", 32'(spawn_valid), 32'h0);
    chk("right_occ", 32'(lane_occupied), 32'h6);
    cyc();
    chk("respawn_valid", 32'(spawn_valid), 32'h1);
    chk("respawn_lane", 32'(spawn_lane), 32'h1);
    accept_one();
    chk("all_occ", 32'(lane_occupied), 32'h7);
    enemy_attack = 1'b1;
    cyc();
    chk("hp2", 32'(player_health), 32'h2);
    cyc();
    chk("hp1", 32'(player_health), 32'h1);
    cyc();
    enemy_attack = 1'b0;
    chk("hp0", 32'(player_health), 32'h0);
    chk("lost", 32'(game_state), 32'h4);
    kill = 3'b001; tick(); kill = 3'b000;
    cyc();
    chk("lost_no_spawn", 32'(spawn_valid), 32'h0);
    chk("lost_kill_ignored", 32'(score), 32'h1);
    start = 1'b1; cyc();
    chk("lost_to_idle", 32'(game_state), 32'h1);
    chk("won_to_idle", 32'(w_state), 32'h1);
    cyc(); start = 1'b0;
    chk("rerun", 32'(game_state), 32'h2);
    tick(); tick(); cyc();
    accept_one();
    chk("g2_occ", 32'(w_occ), 32'h1);
    enemy_attack = 1'b1; cyc(); cyc();
    kill = 3'b001; cyc();
    kill = 3'b000; enemy_attack = 1'b0;
    chk("tie_state", 32'(w_state), 32'h4);
    chk("tie_score", 32'(w_score), 32'h1);
    chk("tie_health", 32'(w_health), 32'h0);
    chk("g2_main_lost", 32'(game_state), 32'h4);
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    tick(); tick(); cyc();
    chk("g3_valid", 32'(spawn_valid), 32'h1);
    rst = 1'b0; spawn_ready = 1'b1; cyc(); spawn_ready = 1'b0;
    chk_reset("midrst");
    rst = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("hold5_lane", 32'(spawn_lane), 32'h1);
    chk("hold5_valid", 32'(spawn_valid), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    chk("hold8_lane", 32'(spawn_lane), 32'h1);
    spawn_ready = 1'b1;
    cyc();
    chk("seq_gap1", 32'(spawn_valid), 32'h0);
    cyc();
    chk("seq_left", 32'({spawn_valid, spawn_lane}), 32'ha);
    cyc();
    chk("seq_gap2", 32'({spawn_valid, lane_occupied}), 32'h3);
    cyc();
    chk("seq_right", 32'({spawn_valid, spawn_lane}), 32'hc);
    cyc();
    spawn_ready = 1'b0;
    chk("seq_done", 32'({spawn_valid, lane_occupied}), 32'h7);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
